// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler and its BCD converter.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CONV_W  = 14;
  localparam int unsigned SAT_VAL = 9999;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam logic DISP_SRC_MMIO = 1'b0;
  localparam logic DISP_SRC_RES  = 1'b1;

  // Blank leading zero digits from d3 downwards, stopping before d0.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] digits);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = digits;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead && (digits[4*i +: 4] == 4'h0)) begin
        res[4*i +: 4] = BLANK_DIGIT;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: captures a clamped binary value on start_i, runs one iteration
// per clock for CONV_W clocks, then pulses done_o with the BCD digits on bcd_o.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BinW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BinW-1:0]  bin_i,
  output logic             sat_o,
  output logic             last_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned CntW = 4;

  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CONV_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;

  assign sat_o  = (bin_i > BinW'(SAT_VAL));
  assign last_o = running_q && (cnt_q == CntW'(CONV_W - 1));
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    running_d = running_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    if (start_i) begin
      running_d = 1'b1;
      cnt_d     = '0;
      bcd_d     = '0;
      bin_d     = sat_o ? CONV_W'(SAT_VAL) : bin_i[CONV_W-1:0];
    end else if (running_q) begin
      {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q + CntW'(1);
      if (last_o) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
    end else begin
      running_q <= running_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Shares the 4-digit display between CPU MMIO writes and BCD-converted compute results.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits of result updates.
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmio_we,
  input  logic [BCD_W-1:0] mmio_wdata,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [BIN_W-1:0] res_data,
  output logic [BCD_W-1:0] disp_data,
  output logic             disp_src,
  output logic             disp_upd,
  output logic             ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] disp_data_q, disp_data_d;
  logic             disp_src_q, disp_src_d;
  logic             disp_upd_q, disp_upd_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             pend_valid_q, pend_valid_d;
  logic [BCD_W-1:0] pend_data_q, pend_data_d;

  logic             conv_start;
  logic             conv_sat;
  logic             conv_last;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] res_digits;

  bin2bcd_seq #(
    .BinW (BIN_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (res_data),
    .sat_o   (conv_sat),
    .last_o  (conv_last),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign res_digits = blank_leading(conv_bcd);
`else
  assign res_digits = conv_bcd;
`endif

  assign res_ready = (state_q == StIdle) && !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    disp_data_d  = disp_data_q;
    disp_src_d   = disp_src_q;
    disp_upd_d   = 1'b0;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    conv_start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          disp_data_d = pend_data_q;
          disp_src_d  = DISP_SRC_MMIO;
          disp_upd_d  = 1'b1;
          // A write landing on the drain edge is newer, so it stays queued.
          if (mmio_we) begin
            pend_data_d = mmio_wdata;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (res_valid) begin
          conv_start = 1'b1;
          ovf_d      = conv_sat;
          busy_d     = 1'b1;
          state_d    = StShift;
          if (mmio_we) begin
            pend_valid_d = 1'b1;
            pend_data_d  = mmio_wdata;
          end
        end else if (mmio_we) begin
          disp_data_d = mmio_wdata;
          disp_src_d  = DISP_SRC_MMIO;
          disp_upd_d  = 1'b1;
        end
      end
      StShift: begin
        if (mmio_we) begin
          pend_valid_d = 1'b1;
          pend_data_d  = mmio_wdata;
        end
        if (conv_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (mmio_we) begin
          pend_valid_d = 1'b1;
          pend_data_d  = mmio_wdata;
        end
        if (conv_done) begin
          disp_data_d = res_digits;
          disp_src_d  = DISP_SRC_RES;
          disp_upd_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      disp_data_q  <= '0;
      disp_src_q   <= DISP_SRC_MMIO;
      disp_upd_q   <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      disp_data_q  <= disp_data_d;
      disp_src_q   <= disp_src_d;
      disp_upd_q   <= disp_upd_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_src  = disp_src_q;
  assign disp_upd  = disp_upd_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched: stimulus pushes expected display updates, a monitor
// pops and checks them whenever disp_upd pulses.
module tb_seg_disp_sched;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] ExpR7   = 16'hFFF7;
  localparam logic [15:0] ExpR55  = 16'hFF55;
  localparam logic [15:0] ExpR100 = 16'hF100;
  localparam logic [15:0] ExpR9   = 16'hFFF9;
  localparam logic [15:0] ExpR300 = 16'hF300;
  localparam logic [15:0] ExpR42  = 16'hFF42;
`else
  localparam logic [15:0] ExpR7   = 16'h0007;
  localparam logic [15:0] ExpR55  = 16'h0055;
  localparam logic [15:0] ExpR100 = 16'h0100;
  localparam logic [15:0] ExpR9   = 16'h0009;
  localparam logic [15:0] ExpR300 = 16'h0300;
  localparam logic [15:0] ExpR42  = 16'h0042;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_we;
  logic [15:0] mmio_wdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [15:0] disp_data;
  logic        disp_src;
  logic        disp_upd;
  logic        ovf;
  logic        busy;

  seg_disp_sched #(
    .BIN_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_we    (mmio_we),
    .mmio_wdata (mmio_wdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .disp_data  (disp_data),
    .disp_src   (disp_src),
    .disp_upd   (disp_upd),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        src;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && disp_upd === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_upd: got disp_data %h at cycle %0d, expected no update",
                 disp_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("disp_data", {16'h0, disp_data}, {16'h0, e.data});
        chk("disp_src", {31'h0, disp_src}, {31'h0, e.src});
        chk("upd_cycle", cyc, e.cyc);
        if (e.src) chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_result(input logic [31:0] v, input logic [15:0] exp_d, input logic eovf,
                             input bit push, output int acc);
    int t = 0;
    res_valid = 1'b1;
    res_data  = v;
    while (res_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL res_accept_timeout: got res_ready %b, expected 1", res_ready);
    end
    acc = cyc + 1;
    if (push) q.push_back('{exp_d, 1'b1, eovf, acc + 15});
    tick();
    res_valid = 1'b0;
    chk("res_ready_after_accept", {31'h0, res_ready}, 32'h0);
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
  endtask

  task automatic mmio_idle(input logic [15:0] d);
    q.push_back('{d, 1'b0, 1'b0, cyc + 1});
    mmio_we    = 1'b1;
    mmio_wdata = d;
    tick();
    mmio_we = 1'b0;
  endtask

  task automatic mmio_raw(input logic [15:0] d);
    mmio_we    = 1'b1;
    mmio_wdata = d;
    tick();
    mmio_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || busy !== 1'b0) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got %0d pending updates, expected 0", q.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_disp_data"}, {16'h0, disp_data}, 32'h0);
    chk({tag, "_disp_src"}, {31'h0, disp_src}, 32'h0);
    chk({tag, "_disp_upd"}, {31'h0, disp_upd}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_res_ready"}, {31'h0, res_ready}, 32'h1);
  endtask

  initial begin
    int acc, acc2;
    rst        = 1'b1;
    mmio_we    = 1'b0;
    mmio_wdata = '0;
    res_valid  = 1'b0;
    res_data   = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // Basic conversion
    send_result(32'd1234, 16'h1234, 1'b0, 1'b1, acc);
    wait_idle();
    chk("r1234_busy_done", {31'h0, busy}, 32'h0);
    chk("r1234_ready_done", {31'h0, res_ready}, 32'h1);
    chk("r1234_disp_held", {16'h0, disp_data}, 32'h1234);

    // Saturation then a small value clearing ovf
    send_result(32'd12345, 16'h9999, 1'b1, 1'b1, acc);
    wait_idle();
    chk("sat_ovf_sticky", {31'h0, ovf}, 32'h1);
    send_result(32'd7, ExpR7, 1'b0, 1'b1, acc);
    wait_idle();

    // MMIO in idle
    mmio_idle(16'hABCD);
    wait_idle();
    chk("mmio_src", {31'h0, disp_src}, 32'h0);

    // Simultaneous write and result: write deferred to E16
    mmio_we    = 1'b1;
    mmio_wdata = 16'h1111;
    send_result(32'd55, ExpR55, 1'b0, 1'b1, acc);
    mmio_we = 1'b0;
    q.push_back('{16'h1111, 1'b0, 1'b0, acc + 16});
    wait_idle();

    // Two writes during SHIFT: last one wins
    send_result(32'd100, ExpR100, 1'b0, 1'b1, acc);
    tick();
    mmio_raw(16'h2222);
    mmio_raw(16'h3333);
    q.push_back('{16'h3333, 1'b0, 1'b0, acc + 16});
    while (cyc < acc + 15) tick();
    chk("res_ready_pending", {31'h0, res_ready}, 32'h0);
    tick();
    chk("res_ready_after_drain", {31'h0, res_ready}, 32'h1);
    wait_idle();

    // Reset at E7 with a write pending: everything discarded
    send_result(32'd5000, 16'h5000, 1'b0, 1'b0, acc);
    tick();
    mmio_raw(16'h4444);
    while (cyc < acc + 6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midreset");
    repeat (20) tick();
    chk("midreset_disp_quiet", {16'h0, disp_data}, 32'h0);
    send_result(32'd9, ExpR9, 1'b0, 1'b1, acc);
    wait_idle();

    // Result held while busy is accepted the edge after res_ready returns
    send_result(32'd300, ExpR300, 1'b0, 1'b1, acc);
    send_result(32'd42, ExpR42, 1'b0, 1'b1, acc2);
    chk("held_accept_cycle", acc2, acc + 16);
    wait_idle();
    repeat (3) tick();

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
- Scheduler and formatter that sits in front of the four-digit seven-segment driver.
- Shares the display between two requesters: CPU MMIO writes (raw 4-bit-per-digit data) and the GCD/compute result (32-bit binary).
- Converts the binary result to 4-digit BCD with a sequential double-dabble.
- Presents one registered 16-bit digit word plus a source flag to the driver.

Parameters:
- BIN_W, 32, width of the binary result input.
- CONV_W, 14, bits converted by double-dabble. Fixed by 4 digits; max 9999 < 2^14.
- SAT_VAL, 9999, clamp value for results that do not fit in 4 digits.

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, synchronous active-high reset.
- mmio_we, input, 1, CPU write strobe to the display register; always accepted.
- mmio_wdata, input, 16, digit word {d3,d2,d1,d0}, 4 bits per digit.
- res_valid, input, 1, result request.
- res_ready, output, 1, scheduler can accept a result.
- res_data, input, BIN_W, binary result.
- disp_data, output, 16, digit word to the driver; [3:0] = least significant digit.
- disp_src, output, 1, 0 = MMIO content, 1 = result content.
- disp_upd, output, 1, one-cycle pulse when disp_data changes.
- ovf, output, 1, last accepted result was saturated; sticky until the next result is accepted.
- busy, output, 1, conversion in progress.

Behaviour:
- Reset values (synchronous, on a clk edge with rst=1):
  - disp_data=16'h0000, disp_src=0, disp_upd=0, ovf=0, busy=0, res_ready=1.
  - Pending MMIO buffer empty; state IDLE.
- Reset mid-conversion: abort the conversion, discard any pending write, apply the reset values above.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - res_ready=1 only if the pending buffer is empty.
  - If pending is valid: disp_data<=pending, disp_src<=0, disp_upd pulses, pending cleared.
  - Else if mmio_we: disp_data<=mmio_wdata, disp_src<=0, disp_upd pulses; the update is visible after that edge.
  - Else if res_valid & res_ready (accepting edge E0):
    - Capture v = (res_data > SAT_VAL) ? SAT_VAL : res_data[CONV_W-1:0].
    - ovf <= (res_data > SAT_VAL).
    - Clear the BCD scratch, cnt<=0, go to SHIFT, busy<=1.
  - If mmio_we and res_valid arrive together in IDLE with no pending: accept the result and store the write in pending. The write is newer, so it wins after the conversion.
- SHIFT:
  - Each edge is one double-dabble iteration: add 3 to each BCD nibble that is >=5, then shift {bcd,bin} left by 1.
  - cnt increments; after 14 iterations (edges E1..E14) go to DONE.
  - res_ready=0.
- DONE (edge E15):
  - disp_data<=bcd, disp_src<=1, disp_upd pulses, busy<=0, go to IDLE.
  - res_ready returns to 1 after E15 if no pending write.
- Result-to-display latency: 15 edges after the accepting edge.
- MMIO during SHIFT/DONE: stored in the one-deep pending buffer. A later write overwrites it (last write wins).
  - Pending is applied on the first IDLE edge (E16).
  - A result cannot be accepted on that edge, because res_ready is low while pending is valid.
- res_valid while res_ready=0: not accepted. The requester holds res_valid and res_data until it is accepted.
- disp_upd is high exactly one cycle per disp_data write, even when the value is unchanged.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: on a result update in DONE, leading zero digits (from d3 down, stopping at d1) are replaced by 4'hF, which the driver shows as blank; d0 is always shown. Example: 42 gives 16'hFF42, 0 gives 16'hFFF0. MMIO data is never modified.
- Undefined: result digits are shown unmodified (42 gives 16'h0042).

Decomposition:
- Shared package seg_pkg holds:
  - State enum (IDLE/SHIFT/DONE).
  - Constants DIGITS=4, CONV_W=14, SAT_VAL=9999, BLANK_DIGIT=4'hF.
  - DISP_SRC_MMIO=0, DISP_SRC_RES=1.
- One sub-module, bin2bcd_seq, contains the capture, the 14-iteration shift and the done pulse.
- The scheduler FSM and pending buffer stay in the top.

Test Plan:
- Reset, then res_data=1234 with res_valid=1 → res_ready drops after E0; 15 edges later disp_data=16'h1234, disp_src=1, disp_upd pulses once, ovf=0, busy=0.
- res_data=12345 → disp_data=16'h9999, ovf=1. Then res_data=7 → ovf=0 and disp_data=16'h0007, or 16'hFFF7 when SEG_LEADING_ZERO_BLANK_EN is defined.
- mmio_we with 16'hABCD in IDLE → disp_data=16'hABCD and disp_src=0 after one edge, disp_upd pulses once.
- mmio_we with 16'h1111 and res_valid with 55 in the same cycle → after E15 disp_data=16'h0055; after E16 disp_data=16'h1111, disp_src=0. Two writes (16'h2222 then 16'h3333) during SHIFT → only 16'h3333 is applied at E16.
- Assert rst at E7 of a conversion → next cycle all outputs take their reset values, no disp_upd. A new result of 9 then completes normally.
- Hold res_valid high with a new value while busy → not accepted until res_ready=1; the second result appears exactly 15 edges after its accepting edge.
